// File: rtl/com_pkg.sv
// Shared definitions for the command sequencer.
// Holds the FSM state encoding, the default parameter values and a helper that
// sizes the retry counter.
package com_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StReq  = 2'd2
  } state_e;

  localparam int unsigned NCmdDefault     = 32;
  localparam int unsigned IdxWDefault     = 5;
  localparam int unsigned AddrWDefault    = 8;
  localparam int unsigned DataWDefault    = 8;
  localparam int unsigned MaxRetryDefault = 3;

  // ceil(log2(max_retry + 1)), floored at one bit so the counter always exists.
  function automatic int unsigned retry_width(input int unsigned max_retry);
    return (max_retry == 0) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/com_table.sv
// Command table: combinationally maps a command index to its sub-address and data.
// Ports:
//   idx_i      - command index
//   sub_addr_o - sub-address (index zero-extended)
//   data_o     - data byte (bitwise NOT of the zero-extended index)
module com_table #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic [IDX_W-1:0]  idx_i,
  output logic [ADDR_W-1:0] sub_addr_o,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    sub_addr_o = ADDR_W'(idx_i);
    data_o     = ~(DATA_W'(idx_i));
  end

endmodule

// File: rtl/com_sequencer.sv
// Command sequencer: walks a table of N_CMD register writes and hands each one to
// an I2C master, retrying on NACK up to MAX_RETRY times before aborting.
// Ports:
//   I2C_clk, reset        - clock, asynchronous active-high reset
//   Start                 - begin a sequence (only honoured when idle)
//   Ack, Nack             - completion status of the current write from the master
//   Write                 - write request to the master
//   SubAddrL, data        - sub-address and data of the current command
//   CmdIdx                - index of the current command
//   Busy, Done, Error     - not idle / one-cycle success pulse / sticky abort flag
module com_sequencer
  import com_pkg::*;
#(
  parameter int unsigned N_CMD     = NCmdDefault,
  parameter int unsigned IDX_W     = IdxWDefault,
  parameter int unsigned ADDR_W    = AddrWDefault,
  parameter int unsigned DATA_W    = DataWDefault,
  parameter int unsigned MAX_RETRY = MaxRetryDefault
) (
  input  logic              I2C_clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Ack,
  input  logic              Nack,
  output logic              Write,
  output logic [ADDR_W-1:0] SubAddrL,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  CmdIdx,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int unsigned        RetryW   = retry_width(MAX_RETRY);
  localparam logic [RetryW-1:0]  MaxRetry = RetryW'(MAX_RETRY);
  localparam logic [IDX_W-1:0]   LastIdx  = IDX_W'(N_CMD - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cmd_idx_q, cmd_idx_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [ADDR_W-1:0]   sub_addr_q, sub_addr_d, tbl_sub_addr;
  logic [DATA_W-1:0]   data_q, data_d, tbl_data;
  logic                write_q, write_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  com_table #(
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_table (
    .idx_i      (cmd_idx_q),
    .sub_addr_o (tbl_sub_addr),
    .data_o     (tbl_data)
  );

  always_comb begin
    state_d    = state_q;
    cmd_idx_d  = cmd_idx_q;
    retry_d    = retry_q;
    sub_addr_d = sub_addr_q;
    data_d     = data_q;
    error_d    = error_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          cmd_idx_d = '0;
          retry_d   = '0;
          error_d   = 1'b0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        sub_addr_d = tbl_sub_addr;
        data_d     = tbl_data;
        state_d    = StReq;
      end
      StReq: begin
        // Ack wins when the master reports both in the same cycle.
        if (Ack) begin
          if (cmd_idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cmd_idx_d = cmd_idx_q + IDX_W'(1);
            retry_d   = '0;
            state_d   = StLoad;
          end
        end else if (Nack) begin
          if (retry_q == MaxRetry) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            // Re-enter LOAD so Write drops for one cycle before the retry.
            retry_d = retry_q + RetryW'(1);
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    write_d = (state_d == StReq);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge I2C_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_idx_q  <= '0;
      retry_q    <= '0;
      sub_addr_q <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_idx_q  <= cmd_idx_d;
      retry_q    <= retry_d;
      sub_addr_q <= sub_addr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign Write    = write_q;
  assign SubAddrL = sub_addr_q;
  assign data     = data_q;
  assign CmdIdx   = cmd_idx_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_com_sequencer.sv
// Bench for com_sequencer: unit 0 uses default parameters, unit 1 the small
// N_CMD=4 / MAX_RETRY=0 configuration. A driver acts as the I2C master while a
// monitor pops expected requests and outcomes from per-unit queues.
module tb_com_sequencer;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] sub;
    logic [7:0] dat;
  } req_t;

  typedef struct packed {
    logic       err;
    logic [4:0] idx;
  } out_t;

  typedef struct packed {
    logic       write;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] idx;
    logic [7:0] sub;
    logic [7:0] dat;
  } obs_t;

  logic clk, rst;
  logic start [2];
  logic ack   [2];
  logic nack  [2];

  logic       w0, b0, dn0, e0, w1, b1, dn1, e1;
  logic [7:0] s0, d0, s1, d1;
  logic [4:0] i0;
  logic [1:0] i1;
  obs_t       ob [2];

  int checks   = 0;
  int failures = 0;
  int plan [32];

  req_t exp_q0[$], exp_q1[$];
  out_t out_q0[$], out_q1[$];

  com_sequencer u_dut0 (
    .I2C_clk (clk), .reset (rst), .Start (start[0]), .Ack (ack[0]), .Nack (nack[0]),
    .Write (w0), .SubAddrL (s0), .data (d0), .CmdIdx (i0),
    .Busy (b0), .Done (dn0), .Error (e0)
  );

  com_sequencer #(
    .N_CMD (4), .IDX_W (2), .ADDR_W (8), .DATA_W (8), .MAX_RETRY (0)
  ) u_dut1 (
    .I2C_clk (clk), .reset (rst), .Start (start[1]), .Ack (ack[1]), .Nack (nack[1]),
    .Write (w1), .SubAddrL (s1), .data (d1), .CmdIdx (i1),
    .Busy (b1), .Done (dn1), .Error (e1)
  );

  always_comb begin
    ob[0] = '{w0, b0, dn0, e0, i0, s0, d0};
    ob[1] = '{w1, b1, dn1, e1, {3'b000, i1}, s1, d1};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int n_cmd(input int u);
    return (u == 0) ? 32 : 4;
  endfunction

  function automatic int max_rt(input int u);
    return (u == 0) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // An event that should never happen counts as a failed comparison.
  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen, required none (t=%0t)", name, $time);
  endtask

  task automatic push_req(input int u, input req_t r);
    if (u == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
  endtask

  task automatic pop_req(input int u, output req_t r);
    if (u == 0) r = exp_q0.pop_front(); else r = exp_q1.pop_front();
  endtask

  function automatic int req_cnt(input int u);
    return (u == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_out(input int u, input out_t o);
    if (u == 0) out_q0.push_back(o); else out_q1.push_back(o);
  endtask

  task automatic pop_out(input int u, output out_t o);
    if (u == 0) o = out_q0.pop_front(); else o = out_q1.pop_front();
  endtask

  function automatic int out_cnt(input int u);
    return (u == 0) ? out_q0.size() : out_q1.size();
  endfunction

  task automatic flush(input int u);
    if (u == 0) begin exp_q0.delete(); out_q0.delete(); end
    else begin exp_q1.delete(); out_q1.delete(); end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 32; i++) plan[i] = 0;
  endtask

  // Reference model: plan[i] NACKs precede the ACK of command i; more NACKs than
  // the retry budget allows end the sequence with an error at that command.
  task automatic model_seq(input int u);
    int n, mr, tries;
    n  = n_cmd(u);
    mr = max_rt(u);
    for (int i = 0; i < n; i++) begin
      tries = (plan[i] > mr) ? mr + 1 : plan[i] + 1;
      for (int t = 0; t < tries; t++)
        push_req(u, '{idx: 5'(i), sub: 8'(i), dat: 8'(255 - i)});
      if (plan[i] > mr) begin
        push_out(u, '{err: 1'b1, idx: 5'(i)});
        return;
      end
    end
    push_out(u, '{err: 1'b0, idx: 5'(n - 1)});
  endtask

  task automatic wait_write(input int u, output bit ok);
    int c;
    c = 0;
    while (!ob[u].write && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    ok = ob[u].write;
    if (!ok) begin
      flag("write_timeout");
      flush(u);
    end
  endtask

  task automatic do_reset(input int u);
    rst = 1'b1;
    #1;
    chk("rst_write", ob[u].write, 0);
    chk("rst_busy",  ob[u].busy,  0);
    chk("rst_done",  ob[u].done,  0);
    chk("rst_error", ob[u].error, 0);
    chk("rst_idx",   ob[u].idx,   0);
    chk("rst_sub",   ob[u].sub,   0);
    chk("rst_dat",   ob[u].dat,   0);
    flush(u);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_write", ob[u].write, 0);
    chk("post_rst_busy",  ob[u].busy,  0);
  endtask

  // Acts as the I2C master for one sequence. chaos adds random response delays,
  // Start pulses while busy, Ack+Nack pairs and stray Ack/Nack in LOAD.
  task automatic run_seq(input int u, input int rst_at, input bit chaos);
    int n, mr, dly;
    bit ok, fin;
    n  = n_cmd(u);
    mr = max_rt(u);
    model_seq(u);
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    chk("start_busy",    ob[u].busy,  1);
    chk("start_err_clr", ob[u].error, 0);
    chk("start_load_wr", ob[u].write, 0);
    @(posedge clk); #1;
    chk("start_latency", ob[u].write, 1);
    for (int i = 0; i < n; i++) begin
      fin = 1'b0;
      for (int t = 0; !fin; t++) begin
        wait_write(u, ok);
        if (!ok) return;
        if (i == rst_at) begin
          do_reset(u);
          return;
        end
        dly = chaos ? int'($urandom_range(0, 3)) : 0;
        repeat (dly) begin
          if (chaos && $urandom_range(0, 2) == 0) start[u] = 1'b1;
          @(posedge clk); #1;
          start[u] = 1'b0;
        end
        if (t == plan[i]) begin
          ack[u]  = 1'b1;
          nack[u] = chaos && ($urandom_range(0, 1) == 1);
          if (chaos && i == n - 1) start[u] = 1'b1;
          fin = 1'b1;
        end else begin
          nack[u] = 1'b1;
        end
        @(posedge clk); #1;
        ack[u]   = 1'b0;
        nack[u]  = 1'b0;
        start[u] = 1'b0;
        if (!fin && t == mr) begin
          chk("abort_error", ob[u].error, 1);
          chk("abort_busy",  ob[u].busy,  0);
          chk("abort_idx",   ob[u].idx,   i);
          repeat (4) @(posedge clk);
          #1;
          chk("abort_hold_err", ob[u].error, 1);
          return;
        end
        if (!(fin && i == n - 1) && chaos && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) ack[u] = 1'b1; else nack[u] = 1'b1;
          @(posedge clk); #1;
          ack[u]  = 1'b0;
          nack[u] = 1'b0;
        end
      end
    end
    repeat (4) @(posedge clk);
    #1;
    chk("end_busy", ob[u].busy, 0);
  endtask

  // Monitor: every request edge, Done pulse and Error rise is matched to the model.
  logic wprev [2];
  logic dprev [2];
  logic eprev [2];
  int   gap   [2];
  logic [7:0] hs [2];
  logic [7:0] hd [2];

  always @(negedge clk) begin : mon
    req_t r;
    out_t o;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        wprev[u] = 1'b0;
        dprev[u] = 1'b0;
        eprev[u] = 1'b0;
        gap[u]   = 0;
      end else begin
        if (ob[u].write && !wprev[u]) begin
          if (req_cnt(u) == 0) begin
            flag("unexpected_write");
          end else begin
            pop_req(u, r);
            chk("req_sub", ob[u].sub, r.sub);
            chk("req_dat", ob[u].dat, r.dat);
            chk("req_idx", ob[u].idx, r.idx);
            chk("req_gap", gap[u], 1);
          end
          hs[u] = ob[u].sub;
          hd[u] = ob[u].dat;
        end else if (ob[u].write) begin
          chk("req_hold", {ob[u].sub, ob[u].dat}, {hs[u], hd[u]});
        end
        if (ob[u].write) gap[u] = 0;
        else if (ob[u].busy) gap[u]++;
        else gap[u] = 0;

        if (ob[u].done) begin
          if (dprev[u]) flag("done_width");
          else if (out_cnt(u) == 0) flag("unexpected_done");
          else begin
            pop_out(u, o);
            chk("done_kind", o.err, 0);
            chk("done_idx",  ob[u].idx,   o.idx);
            chk("done_busy", ob[u].busy,  0);
            chk("done_err",  ob[u].error, 0);
          end
        end
        if (ob[u].error && !eprev[u]) begin
          if (out_cnt(u) == 0) flag("unexpected_error");
          else begin
            pop_out(u, o);
            chk("err_kind", o.err, 1);
            chk("err_idx",  ob[u].idx,  o.idx);
            chk("err_busy", ob[u].busy, 0);
            chk("err_done", ob[u].done, 0);
          end
        end
        wprev[u] = ob[u].write;
        dprev[u] = ob[u].done;
        eprev[u] = ob[u].error;
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      ack[u]   = 1'b0;
      nack[u]  = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("init_write", ob[u].write, 0);
      chk("init_busy",  ob[u].busy,  0);
      chk("init_done",  ob[u].done,  0);
      chk("init_error", ob[u].error, 0);
      chk("init_idx",   ob[u].idx,   0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Nominal, recovery (two NACKs on command 5), abort on command 3.
    clear_plan();
    run_seq(0, -1, 1'b0);
    clear_plan();
    plan[5] = 2;
    run_seq(0, -1, 1'b0);
    clear_plan();
    plan[3] = 4;
    run_seq(0, -1, 1'b0);

    // Contention, then a reset while requesting command 10.
    clear_plan();
    run_seq(0, -1, 1'b1);
    clear_plan();
    run_seq(0, 10, 1'b0);

    for (int k = 0; k < 6; k++) begin
      clear_plan();
      for (int i = 0; i < 32; i++)
        plan[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      if ($urandom_range(0, 2) == 0) plan[$urandom_range(0, 31)] = 4;
      run_seq(0, -1, 1'b1);
    end

    // Small configuration: clean run, immediate abort on one NACK, clean run.
    clear_plan();
    run_seq(1, -1, 1'b1);
    clear_plan();
    plan[2] = 1;
    run_seq(1, -1, 1'b0);
    clear_plan();
    run_seq(1, -1, 1'b0);

    for (int u = 0; u < 2; u++) begin
      chk("leftover_req", req_cnt(u), 0);
      chk("leftover_out", out_cnt(u), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
